mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 128x32 RAM between two requesters: the DMA loader (operand/result buffer fill)
//  and the FPU operand fetch/write-back path. One access per cycle, round-robin between requesters with
//  burst lock-in capped at MAX_BURST beats. Sits between the memory controller's requester ports and the
//  single_port_ram instance; owns all RAM address/we/data drive.
// PARAMETERS
//  ADDR_W     7    RAM address width
//  DATA_W     32   RAM data width
//  DEPTH      128  valid words; addr >= DEPTH is an error (DEPTH <= 2**ADDR_W)
//  MAX_BURST  8    max consecutive grants to one owner while the other waits (>= 1)
// PORTS
//  arb_clk     in   1       clock, rising edge
//  arb_reset   in   1       asynchronous, active-high reset
//  dma_req     in   1       DMA access request; dma_we/addr/wdata valid while high
//  dma_we      in   1       1 = write, 0 = read
//  dma_addr    in   ADDR_W  DMA word address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_gnt     out  1       comb.; access accepted this cycle
//  dma_rvalid  out  1       read data for DMA on arb_rdata
//  fpu_req     in   1       FPU access request
//  fpu_we      in   1       1 = write (result), 0 = read (opa/opb)
//  fpu_addr    in   ADDR_W  FPU word address
//  fpu_wdata   in   DATA_W  FPU write data
//  fpu_gnt     out  1       comb.; access accepted this cycle
//  fpu_rvalid  out  1       read data for FPU on arb_rdata
//  arb_rdata   out  DATA_W  comb. from ram_rdata (zero on error return)
//  arb_err     out  1       one-cycle pulse: accepted access had addr >= DEPTH
//  arb_busy    out  1       state != IDLE
//  ram_addr    out  ADDR_W  registered RAM address
//  ram_we      out  1       registered RAM write enable
//  ram_wdata   out  DATA_W  registered RAM write data
//  ram_rdata   in   DATA_W  RAM read data, valid cycle after ram_addr sampled
// BEHAVIOUR
//  - Reset (async): ram_addr/ram_we/ram_wdata/rvalids/arb_err = 0; state IDLE; last_owner = FPU (DMA wins
//    first tie); beat_cnt = 0; in-flight reads discarded (no rvalid after reset).
//  - State: IDLE, DMA_OWN, FPU_OWN. owner_nxt computed comb. each cycle; gnt_x = (owner_nxt==X) & x_req.
//  - From IDLE: both req -> owner != last_owner; one req -> that one; none -> IDLE.
//  - From O_OWN: O req and (beat_cnt < MAX_BURST-1 or other idle) -> stay O, beat_cnt++ (saturating);
//    else other req -> switch, beat_cnt = 0, last_owner = O; else -> IDLE.
//  - Never both gnt in one cycle; req withdrawn -> no gnt that cycle; req not held after gnt is fine.
//  - Latency: gnt in cycle T -> ram_* driven T+1 -> read data + x_rvalid in T+2 (fixed 2 cycles).
//    Write: ram_we=1 only in T+1; no rvalid. Back-to-back grants pipeline at 1 access/cycle.
//  - No grant in T -> ram_we = 0 in T+1; ram_addr/wdata hold last value.
//  - Error: granted addr >= DEPTH -> still gnt; T+1 ram_we = 0, arb_err = 1; read still returns rvalid
//    in T+2 with arb_rdata = 0. Arbitration unaffected.
//  - Read return tag (owner, is_read, err) shifts through 2-stage pipe; rvalid = tag valid & owner match.
// STRUCTURE
//  - Package mem_arb_pkg: state enum (IDLE/DMA_OWN/FPU_OWN), owner encoding, ADDR_W/DATA_W/DEPTH defaults.
//  - Sub-module mem_arb_rtag_pipe: 2-stage valid/owner/err tag shift register, async reset.
//  - single_port_ram stays outside; this block only drives its ports.
// TESTING
//  - Reset then DMA writes 0x3F800000 to addr 5, FPU reads 5 -> gnt order correct, fpu_rvalid 2 cycles
//    after fpu_gnt with arb_rdata = 0x3F800000, dma_rvalid never set.
//  - Both req continuously from reset, MAX_BURST=8 -> DMA 8 grants, FPU 8, alternating; never both gnt.
//  - DMA burst alone 20 beats (addr 0..19) -> 20 consecutive grants; FPU raises at beat 12 -> switches
//    after beat_cnt limit, DMA resumes after FPU drops.
//  - DMA read addr 127 ok; DEPTH=100 bench: read addr 100 -> arb_err pulse T+1, rvalid T+2 data 0, RAM
//    contents unchanged for write addr 110.
//  - Assert arb_reset between gnt and rvalid of a read -> outputs 0 immediately, no stale rvalid after
//    release; next tie goes to DMA.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the RAM port arbiter
// Purpose: arbitration state encoding, owner encoding, read-return tag
//          layout and default geometry shared by the arbiter files.
// Ports:   none (package).
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 128;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DMA_OWN = 2'd1,
    ST_FPU_OWN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DMA = 1'b0,
    OWN_FPU = 1'b1
  } owner_e;

  // Travels alongside an accepted access until its read data is on arb_rdata.
  typedef struct packed {
    logic   vld;    // accepted read
    owner_e owner;  // requester that gets the data
    logic   err;    // address was out of range, return zero
  } rtag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-side signal bundle for the arbiter
// Purpose: groups both requester ports, the shared read-return bus and the
//          single-port RAM drive into one bundle.
// Ports (slave = arbiter side):
//   dma_req/we/addr/wdata in, dma_gnt/dma_rvalid out
//   fpu_req/we/addr/wdata in, fpu_gnt/fpu_rvalid out
//   arb_rdata/arb_err/arb_busy out
//   ram_addr/ram_we/ram_wdata out, ram_rdata in
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic              fpu_req;
  logic              fpu_we;
  logic [ADDR_W-1:0] fpu_addr;
  logic [DATA_W-1:0] fpu_wdata;
  logic              fpu_gnt;
  logic              fpu_rvalid;

  logic [DATA_W-1:0] arb_rdata;
  logic              arb_err;
  logic              arb_busy;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid,
    input  fpu_req, fpu_we, fpu_addr, fpu_wdata,
    output fpu_gnt, fpu_rvalid,
    output arb_rdata, arb_err, arb_busy,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid,
    output fpu_req, fpu_we, fpu_addr, fpu_wdata,
    input  fpu_gnt, fpu_rvalid,
    input  arb_rdata, arb_err, arb_busy,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arb_rtag_pipe.sv
// rtl/mem_arb_rtag_pipe.sv - two-stage read-return tag delay line
// Purpose: delays the tag of each accepted access by two cycles so it lines
//          up with the RAM read data; reset drops every in-flight tag.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   tag_i  in   tag of the access accepted this cycle
//   tag_o  out  tag of the access accepted two cycles ago
module mem_arb_rtag_pipe
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  rtag_t tag_i,
  output rtag_t tag_o
);

  rtag_t s1_q;
  rtag_t s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= tag_i;
      s2_q <= s1_q;
    end
  end

  assign tag_o = s2_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin DMA/FPU arbiter for the single-port RAM
// Purpose: one RAM access per cycle shared between the DMA loader and the FPU
//          path; round-robin with burst lock-in capped at MAX_BURST grants.
//          Grants are combinational, RAM drive is registered, read data
//          returns two cycles after the grant.
// Ports:
//   arb_clk    in   clock, rising edge
//   arb_reset  in   asynchronous active-high reset
//   bus        slave modport of mem_port_arbiter_if (requesters + RAM)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              arb_clk,
  input  logic              arb_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  arb_state_e        state_q, state_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  owner_e            owner_nxt, cur_own;
  logic              take, cur_req, oth_req;

  logic              sel_we, addr_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              err_q, err_d;

  rtag_t             tag_in, tag_out;

  assign cur_own = (state_q == ST_FPU_OWN) ? OWN_FPU : OWN_DMA;
  assign cur_req = (cur_own == OWN_FPU) ? bus.fpu_req : bus.dma_req;
  assign oth_req = (cur_own == OWN_FPU) ? bus.dma_req : bus.fpu_req;

  // Arbitration: the state records who was granted last cycle, beat_q counts
  // extra grants beyond the first in the current run.
  always_comb begin
    owner_nxt = OWN_DMA;
    take      = 1'b0;
    beat_d    = beat_q;
    last_d    = last_q;
    state_d   = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (bus.dma_req && bus.fpu_req) begin
          take      = 1'b1;
          owner_nxt = (last_q == OWN_DMA) ? OWN_FPU : OWN_DMA;
        end else if (bus.dma_req) begin
          take      = 1'b1;
          owner_nxt = OWN_DMA;
        end else if (bus.fpu_req) begin
          take      = 1'b1;
          owner_nxt = OWN_FPU;
        end
      end
      default: begin
        if (cur_req && (beat_q < BEAT_LAST || !oth_req)) begin
          take      = 1'b1;
          owner_nxt = cur_own;
          if (beat_q < BEAT_LAST) beat_d = beat_q + 1'b1;
        end else if (oth_req) begin
          take      = 1'b1;
          owner_nxt = owner_e'(~cur_own);
          beat_d    = '0;
          last_d    = cur_own;
        end else begin
          beat_d = '0;
        end
      end
    endcase
    if (take) state_d = (owner_nxt == OWN_FPU) ? ST_FPU_OWN : ST_DMA_OWN;
  end

  assign sel_we    = (owner_nxt == OWN_FPU) ? bus.fpu_we    : bus.dma_we;
  assign sel_addr  = (owner_nxt == OWN_FPU) ? bus.fpu_addr  : bus.dma_addr;
  assign sel_wdata = (owner_nxt == OWN_FPU) ? bus.fpu_wdata : bus.dma_wdata;
  assign addr_err  = ({1'b0, sel_addr} >= DEPTH_L);

  // Out-of-range accesses are still accepted but never reach the RAM as writes.
  assign ram_addr_d  = take ? sel_addr  : ram_addr_q;
  assign ram_wdata_d = take ? sel_wdata : ram_wdata_q;
  assign ram_we_d    = take & sel_we & ~addr_err;
  assign err_d       = take & addr_err;

  always_ff @(posedge arb_clk or posedge arb_reset) begin
    if (arb_reset) begin
      state_q     <= ST_IDLE;
      last_q      <= OWN_FPU;
      beat_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      err_q       <= err_d;
    end
  end

  assign tag_in.vld   = take & ~sel_we;
  assign tag_in.owner = owner_nxt;
  assign tag_in.err   = take & addr_err;

  mem_arb_rtag_pipe u_rtag_pipe (
    .clk   (arb_clk),
    .rst   (arb_reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.dma_gnt    = take & (owner_nxt == OWN_DMA);
  assign bus.fpu_gnt    = take & (owner_nxt == OWN_FPU);
  assign bus.dma_rvalid = tag_out.vld & (tag_out.owner == OWN_DMA);
  assign bus.fpu_rvalid = tag_out.vld & (tag_out.owner == OWN_FPU);
  assign bus.arb_rdata  = tag_out.err ? '0 : bus.ram_rdata;
  assign bus.arb_err    = err_q;
  assign bus.arb_busy   = (state_q != ST_IDLE);
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int DEPTH_A = 128;
  localparam int DEPTH_B = 100;

  logic clk = 1'b0;
  logic rst;
  logic ram_clear;
  always #5 clk = ~clk;

  logic          s_dma_req, s_dma_we, s_fpu_req, s_fpu_we;
  logic [AW-1:0] s_dma_addr, s_fpu_addr;
  logic [DW-1:0] s_dma_wdata, s_fpu_wdata;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_A), .MAX_BURST(MB)) dut_a (
    .arb_clk(clk), .arb_reset(rst), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_B), .MAX_BURST(MB)) dut_b (
    .arb_clk(clk), .arb_reset(rst), .bus(bus_b));

  assign bus_a.dma_req = s_dma_req;    assign bus_b.dma_req = s_dma_req;
  assign bus_a.dma_we = s_dma_we;      assign bus_b.dma_we = s_dma_we;
  assign bus_a.dma_addr = s_dma_addr;  assign bus_b.dma_addr = s_dma_addr;
  assign bus_a.dma_wdata = s_dma_wdata; assign bus_b.dma_wdata = s_dma_wdata;
  assign bus_a.fpu_req = s_fpu_req;    assign bus_b.fpu_req = s_fpu_req;
  assign bus_a.fpu_we = s_fpu_we;      assign bus_b.fpu_we = s_fpu_we;
  assign bus_a.fpu_addr = s_fpu_addr;  assign bus_b.fpu_addr = s_fpu_addr;
  assign bus_a.fpu_wdata = s_fpu_wdata; assign bus_b.fpu_wdata = s_fpu_wdata;

  logic          o_dgnt[2], o_fgnt[2], o_drv[2], o_frv[2], o_err[2], o_busy[2], o_we[2];
  logic [AW-1:0] o_addr[2];
  logic [DW-1:0] o_wdata[2], o_rdata[2];

  assign o_dgnt[0] = bus_a.dma_gnt;     assign o_dgnt[1] = bus_b.dma_gnt;
  assign o_fgnt[0] = bus_a.fpu_gnt;     assign o_fgnt[1] = bus_b.fpu_gnt;
  assign o_drv[0] = bus_a.dma_rvalid;   assign o_drv[1] = bus_b.dma_rvalid;
  assign o_frv[0] = bus_a.fpu_rvalid;   assign o_frv[1] = bus_b.fpu_rvalid;
  assign o_err[0] = bus_a.arb_err;      assign o_err[1] = bus_b.arb_err;
  assign o_busy[0] = bus_a.arb_busy;    assign o_busy[1] = bus_b.arb_busy;
  assign o_we[0] = bus_a.ram_we;        assign o_we[1] = bus_b.ram_we;
  assign o_addr[0] = bus_a.ram_addr;    assign o_addr[1] = bus_b.ram_addr;
  assign o_wdata[0] = bus_a.ram_wdata;  assign o_wdata[1] = bus_b.ram_wdata;
  assign o_rdata[0] = bus_a.arb_rdata;  assign o_rdata[1] = bus_b.arb_rdata;

  // Single-port RAM behaviour: registered read, one cycle after the address.
  logic [DW-1:0] ram_mem[2][128];
  logic [DW-1:0] ram_q[2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_clear) begin
        for (int i = 0; i < 128; i++) ram_mem[k][i] <= '0;
      end else if (o_we[k]) begin
        ram_mem[k][o_addr[k]] <= o_wdata[k];
      end
      ram_q[k] <= ram_mem[k][o_addr[k]];
    end
  end
  assign bus_a.ram_rdata = ram_q[0];
  assign bus_b.ram_rdata = ram_q[1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many grants in the current run,
  // who lost the last switch, plus what each accepted access should produce.
  typedef struct packed {
    logic          gnt, we, err, rd;
    logic [1:0]    own;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
  } slot_t;

  int            m_own, m_run, m_last;
  slot_t         due1[2], due2[2];
  logic [DW-1:0] exp_mem[2][128];

  function automatic int depth_of(input int k);
    return (k == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  task automatic model_reset();
    m_own = 0; m_run = 0; m_last = 2;
    for (int k = 0; k < 2; k++) begin
      due1[k] = '0;
      due2[k] = '0;
    end
  endtask

  task automatic step();
    int nxt;
    logic own_req, oth_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    slot_t g;
    for (int k = 0; k < 2; k++)
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_own != 0));
    nxt = 0;
    if (m_own == 0) begin
      if (s_dma_req && s_fpu_req) nxt = (m_last == 1) ? 2 : 1;
      else if (s_dma_req) nxt = 1;
      else if (s_fpu_req) nxt = 2;
      m_run = (nxt != 0) ? 1 : 0;
    end else begin
      own_req = (m_own == 1) ? s_dma_req : s_fpu_req;
      oth_req = (m_own == 1) ? s_fpu_req : s_dma_req;
      if (own_req && (m_run < MB || !oth_req)) begin
        nxt = m_own; m_run++;
      end else if (oth_req) begin
        nxt = 3 - m_own; m_last = m_own; m_run = 1;
      end else begin
        nxt = 0; m_run = 0;
      end
    end
    a_we    = (nxt == 2) ? s_fpu_we    : s_dma_we;
    a_addr  = (nxt == 2) ? s_fpu_addr  : s_dma_addr;
    a_wdata = (nxt == 2) ? s_fpu_wdata : s_dma_wdata;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ram_we%0d", k), 32'(o_we[k]), 32'(due1[k].we));
      chk($sformatf("arb_err%0d", k), 32'(o_err[k]), 32'(due1[k].err));
      if (due1[k].gnt && !due1[k].err)
        chk($sformatf("ram_addr%0d", k), 32'(o_addr[k]), 32'(due1[k].addr));
      if (due1[k].we) begin
        chk($sformatf("ram_wdata%0d", k), o_wdata[k], due1[k].wdata);
        exp_mem[k][due1[k].addr] = due1[k].wdata;
      end
      chk($sformatf("dma_rvalid%0d", k), 32'(o_drv[k]), 32'(due2[k].rd && due2[k].own == 2'd1));
      chk($sformatf("fpu_rvalid%0d", k), 32'(o_frv[k]), 32'(due2[k].rd && due2[k].own == 2'd2));
      if (due2[k].rd) chk($sformatf("arb_rdata%0d", k), o_rdata[k], due2[k].rdata);
      chk($sformatf("dma_gnt%0d", k), 32'(o_dgnt[k]), 32'(nxt == 1));
      chk($sformatf("fpu_gnt%0d", k), 32'(o_fgnt[k]), 32'(nxt == 2));
      g = '0;
      if (nxt != 0) begin
        g.gnt   = 1'b1;
        g.own   = 2'(nxt);
        g.addr  = a_addr;
        g.wdata = a_wdata;
        g.err   = (int'(a_addr) >= depth_of(k));
        g.we    = a_we && !g.err;
        g.rd    = !a_we;
        g.rdata = g.err ? '0 : exp_mem[k][a_addr];
      end
      due2[k] = due1[k];
      due1[k] = g;
    end
    m_own = nxt;
  endtask

  task automatic cycle(input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic fr, input logic fw, input logic [AW-1:0] fa, input logic [DW-1:0] fd);
    @(posedge clk); #1;
    s_dma_req = dr; s_dma_we = dw; s_dma_addr = da; s_dma_wdata = dd;
    s_fpu_req = fr; s_fpu_we = fw; s_fpu_addr = fa; s_fpu_wdata = fd;
    @(negedge clk);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_reset_state(input string why);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ram_we%0d", why, k), 32'(o_we[k]), 0);
      chk($sformatf("%s_err%0d", why, k), 32'(o_err[k]), 0);
      chk($sformatf("%s_drv%0d", why, k), 32'(o_drv[k]), 0);
      chk($sformatf("%s_frv%0d", why, k), 32'(o_frv[k]), 0);
      chk($sformatf("%s_busy%0d", why, k), 32'(o_busy[k]), 0);
      chk($sformatf("%s_addr%0d", why, k), 32'(o_addr[k]), 0);
      chk($sformatf("%s_wdata%0d", why, k), o_wdata[k], 0);
    end
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic apply_reset(input string why);
    @(posedge clk); #1;
    s_dma_req = 1'b0; s_fpu_req = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset_state(why);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int nd, nf, nd8, nf16, beat, fg, n, first_f;
    rst = 1'b1; ram_clear = 1'b1;
    s_dma_req = 1'b0; s_dma_we = 1'b0; s_dma_addr = '0; s_dma_wdata = '0;
    s_fpu_req = 1'b0; s_fpu_we = 1'b0; s_fpu_addr = '0; s_fpu_wdata = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++) exp_mem[k][i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    @(posedge clk); #1 rst = 1'b0; ram_clear = 1'b0;

    // DMA write then FPU read of the same word.
    cycle(1'b1, 1'b1, 7'd5, 32'h3F80_0000, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd5, '0);
    idle(2);
    chk("t1_fpu_rvalid", 32'(o_frv[0]), 1);
    chk("t1_rdata", o_rdata[0], 32'h3F80_0000);
    idle(1);

    // Both requesting continuously from reset.
    apply_reset("t2rst");
    nd = 0; nf = 0; nd8 = 0; nf16 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(64 + i), '0);
      nd += int'(o_dgnt[0]); nf += int'(o_fgnt[0]);
      if (i < 8) nd8 += int'(o_dgnt[0]);
      else if (i < 16) nf16 += int'(o_fgnt[0]);
    end
    idle(3);
    chk("t2_dma_first8", nd8, 8);
    chk("t2_fpu_next8", nf16, 8);
    chk("t2_dma_total", nd, 16);
    chk("t2_fpu_total", nf, 16);

    // DMA burst of 20 writes; FPU steps in after beat 12 for three reads.
    beat = 0; fg = 0; n = 0; first_f = -1;
    while (beat < 20 && n < 80) begin
      cycle(1'b1, 1'b1, AW'(beat), 32'hD000_0000 + 32'(beat), 1'(beat >= 12 && fg < 3), 1'b0, 7'd40, '0);
      if (o_fgnt[0] && first_f < 0) first_f = n;
      beat += int'(o_dgnt[0]); fg += int'(o_fgnt[0]); n++;
    end
    idle(3);
    chk("t3_beats", beat, 20);
    chk("t3_fpu_grants", fg, 3);
    chk("t3_switch_cycle", first_f, 12);
    chk("t3_total_cycles", n, 23);

    // Address range: 127 fine at depth 128, out of range at depth 100.
    cycle(1'b1, 1'b0, 7'd127, '0, 1'b0, 1'b0, '0, '0);
    idle(1);
    chk("t4_err_a", 32'(o_err[0]), 0);
    chk("t4_err_b", 32'(o_err[1]), 1);
    idle(1);
    chk("t4_rvalid_b", 32'(o_drv[1]), 1);
    chk("t4_rdata_b", o_rdata[1], 0);
    cycle(1'b1, 1'b0, 7'd100, '0, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd110, 32'hCAFE_0110);
    idle(2);
    chk("t4_mem110_a", ram_mem[0][110], 32'hCAFE_0110);
    chk("t4_mem110_b", ram_mem[1][110], 0);

    // Reset between grant and read return.
    cycle(1'b1, 1'b0, 7'd3, '0, 1'b0, 1'b0, '0, '0);
    apply_reset("t5rst");
    idle(3);
    cycle(1'b1, 1'b0, 7'd7, '0, 1'b1, 1'b0, 7'd8, '0);
    chk("t5_tie_dma", 32'(o_dgnt[0]), 1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), $urandom,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), $urandom);
    idle(3);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++)
        chk($sformatf("mem%0d[%0d]", k, i), ram_mem[k][i], exp_mem[k][i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
